// File: rtl/reg_file_writeback_pkg.sv
// Shared register-file writeback types and sizing constants.
package reg_file_writeback_pkg;

  localparam int MSB_POS__REG_FILE_SEL         = 3;
  localparam int MSB_POS__REG_FILE_DATA        = 31;
  localparam int LAST_INDEX__REG_FILE_NUM_REGS = (2 ** (MSB_POS__REG_FILE_SEL + 1)) - 1;

  // One result headed for the register file write port.
  typedef struct packed {
    logic                              valid;
    logic [MSB_POS__REG_FILE_SEL:0]    sel;
    logic [MSB_POS__REG_FILE_DATA:0]   data;
  } PortIn_RegFileWb;

  // Register 0 is hardwired zero; a result aimed at it is never written.
  function automatic logic is_null_sel(input logic [MSB_POS__REG_FILE_SEL:0] sel);
    return (sel == '0);
  endfunction

endpackage

// File: rtl/reg_file_wb_load_fifo.sv
// Small synchronous FIFO buffering load results while the write port is busy.
// The head is read combinationally so a waiting entry can be written the
// cycle the port frees up.
module reg_file_wb_load_fifo
  import reg_file_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  PortIn_RegFileWb push_entry_i,
  input  logic            pop_i,
  output PortIn_RegFileWb head_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  PortIn_RegFileWb  mem_q [DEPTH];

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/reg_file_writeback.sv
// Writeback arbiter: merges the ALU path and the load-return path into the
// single register-file write port, and tracks outstanding loads per register.
module reg_file_writeback
  import reg_file_writeback_pkg::*;
#(
  parameter int LOAD_FIFO_DEPTH = 2,
  parameter int NUM_REGS        = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_alu_valid,
  input  logic [MSB_POS__REG_FILE_SEL:0]  in_alu_sel,
  input  logic [MSB_POS__REG_FILE_DATA:0] in_alu_data,
  input  logic                            in_ld_valid,
  output logic                            out_ld_ready,
  input  logic [MSB_POS__REG_FILE_SEL:0]  in_ld_sel,
  input  logic [MSB_POS__REG_FILE_DATA:0] in_ld_data,
  input  logic                            in_ld_issue_valid,
  input  logic [MSB_POS__REG_FILE_SEL:0]  in_ld_issue_sel,
  output logic [NUM_REGS-1:0]             out_busy,
  output logic                            out_write_en,
  output logic [MSB_POS__REG_FILE_SEL:0]  out_write_sel,
  output logic [MSB_POS__REG_FILE_DATA:0] out_write_data
);

  PortIn_RegFileWb alu_in, ld_in, fifo_head, win;
  logic            fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic            alu_take, head_avail, fifo_sel, bypass, ld_clear;

  logic                            wr_en_q, wr_en_d;
  logic [MSB_POS__REG_FILE_SEL:0]  wr_sel_q, wr_sel_d;
  logic [MSB_POS__REG_FILE_DATA:0] wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;

  assign alu_in = '{valid: in_alu_valid, sel: in_alu_sel, data: in_alu_data};
  assign ld_in  = '{valid: in_ld_valid,  sel: in_ld_sel,  data: in_ld_data};

  reg_file_wb_load_fifo #(
    .DEPTH (LOAD_FIFO_DEPTH)
  ) u_load_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (fifo_push),
    .push_entry_i (ld_in),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  // Readiness depends only on registered occupancy, never on in_ld_valid.
  assign out_ld_ready = !fifo_full;

  // Arbitration (ALU > FIFO head > bypass), FIFO control and scoreboard next-state.
  always_comb begin
    alu_take   = in_alu_valid && !is_null_sel(in_alu_sel);
    head_avail = !fifo_empty && fifo_head.valid;
    fifo_sel   = !alu_take && head_avail;
    bypass     = !alu_take && !head_avail && in_ld_valid;
    // A null head is discarded even while the ALU holds the port.
    fifo_pop   = head_avail && (fifo_sel || is_null_sel(fifo_head.sel));
    fifo_push  = in_ld_valid && !fifo_full && !bypass;

    win      = '0;
    ld_clear = 1'b0;
    if (alu_take) begin
      win = alu_in;
    end else if (fifo_sel) begin
      win      = fifo_head;
      ld_clear = 1'b1;
    end else if (bypass) begin
      win      = ld_in;
      ld_clear = 1'b1;
    end

    wr_en_d   = win.valid && !is_null_sel(win.sel);
    wr_sel_d  = wr_en_d ? win.sel  : '0;
    wr_data_d = wr_en_d ? win.data : '0;

    // Clear first so a same-cycle issue to the same register wins.
    busy_d = busy_q;
    if (ld_clear)          busy_d[win.sel]         = 1'b0;
    if (in_ld_issue_valid) busy_d[in_ld_issue_sel] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Registered write port and busy scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign out_write_en   = wr_en_q;
  assign out_write_sel  = wr_sel_q;
  assign out_write_data = wr_data_q;
  assign out_busy       = busy_q;

endmodule

// File: tb/tb_reg_file_writeback.sv
// Scoreboard bench for reg_file_writeback: a behavioural model of the
// arbiter/FIFO/scoreboard pushes the expected write per cycle, and the
// registered DUT output is popped and compared one cycle later.
module tb_reg_file_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_alu_valid = 1'b0;
  logic [3:0]  in_alu_sel = '0;
  logic [31:0] in_alu_data = '0;
  logic        in_ld_valid = 1'b0;
  logic        out_ld_ready;
  logic [3:0]  in_ld_sel = '0;
  logic [31:0] in_ld_data = '0;
  logic        in_ld_issue_valid = 1'b0;
  logic [3:0]  in_ld_issue_sel = '0;
  logic [15:0] out_busy;
  logic        out_write_en;
  logic [3:0]  out_write_sel;
  logic [31:0] out_write_data;

  typedef struct {
    logic        en;
    logic [3:0]  sel;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_fifo[$];
  logic [15:0] m_busy = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  reg_file_writeback #(
    .LOAD_FIFO_DEPTH (DEPTH),
    .NUM_REGS        (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_alu_valid      (in_alu_valid),
    .in_alu_sel        (in_alu_sel),
    .in_alu_data       (in_alu_data),
    .in_ld_valid       (in_ld_valid),
    .out_ld_ready      (out_ld_ready),
    .in_ld_sel         (in_ld_sel),
    .in_ld_data        (in_ld_data),
    .in_ld_issue_valid (in_ld_issue_valid),
    .in_ld_issue_sel   (in_ld_issue_sel),
    .out_busy          (out_busy),
    .out_write_en      (out_write_en),
    .out_write_sel     (out_write_sel),
    .out_write_data    (out_write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    in_alu_valid      = 1'b0;
    in_alu_sel        = '0;
    in_alu_data       = '0;
    in_ld_valid       = 1'b0;
    in_ld_sel         = '0;
    in_ld_data        = '0;
    in_ld_issue_valid = 1'b0;
    in_ld_issue_sel   = '0;
  endtask

  // One clock cycle: model the cycle with the current inputs, push the
  // expected write, cross the edge, then pop and compare the DUT output.
  task automatic step(output bit accepted);
    exp_t        e;
    exp_t        h;
    bit          alu_take, ready, bypass;
    int          clr;
    logic [15:0] nbusy;

    ready = (m_fifo.size() < DEPTH);
    check("ld_ready", {63'd0, out_ld_ready}, {63'd0, ready});
    alu_take = in_alu_valid && (in_alu_sel != 4'd0);
    if (alu_take) check("alu_dst_busy", {63'd0, out_busy[in_alu_sel]}, 64'd0);

    e = '{en: 1'b0, sel: 4'd0, data: 32'd0};
    clr = -1;
    bypass = 1'b0;
    if (alu_take) begin
      e = '{en: 1'b1, sel: in_alu_sel, data: in_alu_data};
    end else if (m_fifo.size() > 0) begin
      h = m_fifo.pop_front();
      clr = int'(h.sel);
      if (h.sel != 4'd0) e = h;
    end else if (in_ld_valid) begin
      bypass = 1'b1;
      clr = int'(in_ld_sel);
      if (in_ld_sel != 4'd0) e = '{en: 1'b1, sel: in_ld_sel, data: in_ld_data};
    end
    if (alu_take && m_fifo.size() > 0 && m_fifo[0].sel == 4'd0) void'(m_fifo.pop_front());
    accepted = in_ld_valid && ready;
    if (accepted && !bypass) m_fifo.push_back('{en: 1'b1, sel: in_ld_sel, data: in_ld_data});

    nbusy = m_busy;
    if (clr >= 0) nbusy[clr] = 1'b0;
    if (in_ld_issue_valid) nbusy[in_ld_issue_sel] = 1'b1;
    nbusy[0] = 1'b0;
    m_busy = nbusy;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("write_en", {63'd0, out_write_en}, {63'd0, e.en});
    if (e.en) begin
      check("write_sel", {60'd0, out_write_sel}, {60'd0, e.sel});
      check("write_data", {32'd0, out_write_data}, {32'd0, e.data});
      $display("write r%0d = 0x%08h at %0t", out_write_sel, out_write_data, $time);
    end
    check("busy", {48'd0, out_busy}, {48'd0, m_busy});
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    set_idle();
    for (int i = 0; i < n; i++) step(acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    {63'd0, out_write_en},    64'd0);
    check({tag, "_sel"},   {60'd0, out_write_sel},   64'd0);
    check({tag, "_data"},  {32'd0, out_write_data},  64'd0);
    check({tag, "_busy"},  {48'd0, out_busy},        64'd0);
    check({tag, "_ready"}, {63'd0, out_ld_ready},    64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int li;
    int r8_cycle;
    logic [3:0]  ld_sels [3];
    logic [31:0] ld_datas[3];

    set_idle();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // ALU write, 1-cycle latency, then quiet
    in_alu_valid = 1'b1; in_alu_sel = 4'd3; in_alu_data = 32'h12345678;
    step(acc);
    idle_cycles(2);

    // Issue load to r5, bypass return two cycles later
    in_ld_issue_valid = 1'b1; in_ld_issue_sel = 4'd5;
    step(acc);
    idle_cycles(1);
    in_ld_valid = 1'b1; in_ld_sel = 4'd5; in_ld_data = 32'hDEADBEEF;
    step(acc);
    idle_cycles(2);

    // ALU holds the port for 4 cycles while three loads back up
    set_idle();
    in_ld_issue_valid = 1'b1;
    for (int i = 6; i <= 8; i++) begin
      in_ld_issue_sel = 4'(i);
      step(acc);
    end
    ld_sels[0] = 4'd6; ld_datas[0] = 32'hA0000006;
    ld_sels[1] = 4'd7; ld_datas[1] = 32'hA0000007;
    ld_sels[2] = 4'd8; ld_datas[2] = 32'hA0000008;
    li = 0;
    r8_cycle = -1;
    for (int c = 0; c < 10; c++) begin
      set_idle();
      if (c < 4) begin
        in_alu_valid = 1'b1; in_alu_sel = 4'd1; in_alu_data = 32'h1000 + 32'(c);
      end
      if (li < 3) begin
        in_ld_valid = 1'b1; in_ld_sel = ld_sels[li]; in_ld_data = ld_datas[li];
      end
      step(acc);
      if (acc) begin
        if (li == 2) r8_cycle = c;
        li++;
      end
    end
    check("r8_accept_cycle", 64'(r8_cycle), 64'd5);

    // Load return and new issue to r9 in the same cycle: set wins
    set_idle();
    in_ld_issue_valid = 1'b1; in_ld_issue_sel = 4'd9;
    step(acc);
    in_ld_valid = 1'b1; in_ld_sel = 4'd9; in_ld_data = 32'h99990001;
    step(acc);
    check("busy9_set_wins", {63'd0, out_busy[9]}, 64'd1);
    in_ld_issue_valid = 1'b0;
    in_ld_data = 32'h99990002;
    step(acc);
    idle_cycles(1);

    // Null traffic to r0: bypassed null, buffered null, ignored issue
    set_idle();
    in_alu_valid = 1'b1; in_alu_sel = 4'd0; in_alu_data = 32'hBAD0;
    in_ld_valid = 1'b1;  in_ld_sel = 4'd0;  in_ld_data = 32'hBAD1;
    in_ld_issue_valid = 1'b1; in_ld_issue_sel = 4'd0;
    step(acc);
    in_alu_sel = 4'd2; in_alu_data = 32'h2222;
    in_ld_data = 32'hBAD2;
    step(acc);
    in_ld_valid = 1'b0;
    in_alu_sel = 4'd0; in_alu_data = 32'hBAD3;
    step(acc);
    idle_cycles(2);
    check("r0_fifo_drained_ready", {63'd0, out_ld_ready}, 64'd1);

    // Async reset with two buffered loads and busy = 0x00C0
    set_idle();
    in_ld_issue_valid = 1'b1;
    in_ld_issue_sel = 4'd6; step(acc);
    in_ld_issue_sel = 4'd7; step(acc);
    set_idle();
    in_alu_valid = 1'b1; in_alu_sel = 4'd1; in_alu_data = 32'h5555;
    in_ld_valid = 1'b1; in_ld_sel = 4'd6; in_ld_data = 32'h66;
    step(acc);
    in_ld_sel = 4'd7; in_ld_data = 32'h77;
    step(acc);
    in_ld_valid = 1'b0;
    step(acc);
    check("pre_reset_busy", {48'd0, out_busy}, 64'h00C0);
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_fifo.delete();
    exp_q.delete();
    m_busy = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
